// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: instruction
// decode codes, FSM state encoding and iteration count.
package mips_muldiv_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = $clog2(ITER_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      FIX
   } muldivState_e;

   function automatic logic isClassFunct(input logic [5:0] fn);
      return fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shared adder/subtractor, a HI/LO shift pair and the
// iteration counter. Works on unsigned magnitudes only.
module muldiv_iter_core
   import mips_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            step_i,
   input  logic            isDiv_i,
   input  logic [XLEN-1:0] opA_i,
   input  logic [XLEN-1:0] opB_i,
   output logic            lastIter_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN-1:0]  opB_q, opB_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN+1:0]  base, operand, sum;

   // Divide subtracts the divisor from the shifted partial remainder; the extra
   // top bit is a clean borrow flag even when the divisor is zero.
   always_comb begin
      base    = isDiv_i ? {1'b0, hi_q, lo_q[XLEN-1]} : {2'b00, hi_q};
      operand = isDiv_i ? ~{2'b00, opB_q} : {2'b00, {XLEN{lo_q[0]}} & opB_q};
      sum     = base + operand + {{(XLEN+1){1'b0}}, isDiv_i};
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      opB_d = opB_q;
      cnt_d = cnt_q;
      if (start_i) begin
         hi_d  = '0;
         lo_d  = opA_i;
         opB_d = opB_i;
         cnt_d = '0;
      end else if (step_i) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (isDiv_i) begin
            if (!sum[XLEN+1]) begin
               hi_d = sum[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_d = base[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opB_q <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         opB_q <= opB_d;
         cnt_q <= cnt_d;
      end
   end

   assign lastIter_o = (cnt_q == CNT_W'(ITER_COUNT - 1));
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: rtl/execute_muldiv_unit.sv
// Execute-stage MULT/DIV unit: decode, sequencing FSM, sign handling, the
// architectural HI/LO registers and MFHI/MFLO/MTHI/MTLO service.
module execute_muldiv_unit
   import mips_muldiv_pkg::*;
#(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] DIV0_LO = 32'hFFFFFFFF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   input  logic [31:0]     instrData_i,
   input  logic [XLEN-1:0] rsData_i,
   input  logic [XLEN-1:0] rtData_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic [XLEN-1:0] mfResult_o,
   output logic            mfValid_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   muldivState_e    state_q, state_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
   logic            isDiv_q, isDiv_d, negRes_q, negRes_d;
   logic            negRem_q, negRem_d, divZero_q, divZero_d;

   logic [5:0]        opcode, funct;
   logic              unusedInstrBits;
   logic              isClass, isMulDiv, isDivOp, isSigned, accept;
   logic              rsNeg, rtNeg;
   logic [XLEN-1:0]   rsMag, rtMag;
   logic              coreStart, coreStep, coreLast;
   logic [XLEN-1:0]   coreHi, coreLo;
   logic [2*XLEN-1:0] product;

   assign opcode          = instrData_i[31:26];
   assign funct           = instrData_i[5:0];
   assign unusedInstrBits = ^instrData_i[25:6];

   assign isClass  = (opcode == OP_SPECIAL) && isClassFunct(funct);
   assign isMulDiv = isClass && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
   assign isDivOp  = (funct == FN_DIV) || (funct == FN_DIVU);
   assign isSigned = (funct == FN_MULT) || (funct == FN_DIV);
   assign rsNeg    = isSigned & rsData_i[XLEN-1];
   assign rtNeg    = isSigned & rtData_i[XLEN-1];
   assign rsMag    = rsNeg ? -rsData_i : rsData_i;
   assign rtMag    = rtNeg ? -rtData_i : rtData_i;

   assign busy_o  = (state_q != IDLE);
   assign accept  = valid_i & isClass & ~busy_o;
   assign stall_o = valid_i & isClass & busy_o;

   assign mfValid_o  = accept & ((funct == FN_MFHI) || (funct == FN_MFLO));
   assign mfResult_o = !mfValid_o ? '0 : (funct == FN_MFHI) ? hi_q : lo_q;

   assign product = {coreHi, coreLo};

   // The core sees magnitudes only; signs are captured at start and re-applied
   // in FIX. A zero divisor still runs the full sequence so latency is fixed.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      coreStart = 1'b0;
      coreStep  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && isMulDiv) begin
               coreStart = 1'b1;
               isDiv_d   = isDivOp;
               negRes_d  = rsNeg ^ rtNeg;
               negRem_d  = rsNeg;
               divZero_d = (rtData_i == '0);
               state_d   = isDivOp ? DIV : MUL;
            end else if (accept && funct == FN_MTHI) begin
               hi_d = rsData_i;
            end else if (accept && funct == FN_MTLO) begin
               lo_d = rsData_i;
            end
         end
         MUL, DIV: begin
            coreStep = 1'b1;
            if (coreLast) state_d = FIX;
         end
         FIX: begin
            if (!isDiv_q) begin
               {hi_d, lo_d} = negRes_q ? -product : product;
            end else begin
               hi_d = negRem_q ? -coreHi : coreHi;
               lo_d = divZero_q ? DIV0_LO : (negRes_q ? -coreLo : coreLo);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
      end
   end

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (coreStart),
      .step_i     (coreStep),
      .isDiv_i    (isDiv_q),
      .opA_i      (rsMag),
      .opB_i      (rtMag),
      .lastIter_o (coreLast),
      .hi_o       (coreHi),
      .lo_o       (coreLo)
   );

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit with an arithmetic reference model
// checked against the DUT every cycle.
module tb_execute_muldiv_unit;

   localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
   localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
   localparam logic [5:0] FN_ADD  = 6'h20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        validIn = 1'b0;
   logic [31:0] instrIn = '0;
   logic [31:0] rsIn = '0, rtIn = '0;
   logic        busy_o, stall_o, mfValid_o;
   logic [31:0] mfResult_o, hi_o, lo_o;

   int checks = 0;
   int failures = 0;

   int          mRemain = 0;
   logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
   logic        expBusy;

   always #5 clk = ~clk;

   execute_muldiv_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (validIn),
      .instrData_i (instrIn),
      .rsData_i    (rsIn),
      .rtData_i    (rtIn),
      .busy_o      (busy_o),
      .stall_o     (stall_o),
      .mfResult_o  (mfResult_o),
      .mfValid_o   (mfValid_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   function automatic logic tbIsClass(input logic [31:0] w);
      return (w[31:26] == 6'h00) && (w[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]});
   endfunction

   // Reference result {HI, LO} from plain integer arithmetic.
   function automatic logic [63:0] expectResult(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
      longint a, b, q, r;
      logic [63:0] ua, ub, uq, ur;
      a  = $signed(rs);
      b  = $signed(rt);
      ua = {32'h0, rs};
      ub = {32'h0, rt};
      case (fn)
         FN_MULT:  return a * b;
         FN_MULTU: return ua * ub;
         FN_DIV: begin
            if (rt == 0) return {rs, 32'hFFFFFFFF};
            q = a / b;
            r = a % b;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (rt == 0) return {rs, 32'hFFFFFFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   assign expBusy = (mRemain != 0);

   // Reference model: an accepted MULT/DIV occupies the unit for 33 edges and
   // commits its result on the last one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mRemain <= 0;
         mHi     <= '0;
         mLo     <= '0;
      end else if (mRemain > 0) begin
         mRemain <= mRemain - 1;
         if (mRemain == 1) begin
            mHi <= pHi;
            mLo <= pLo;
         end
      end else if (validIn && tbIsClass(instrIn)) begin
         case (instrIn[5:0])
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
               {pHi, pLo} <= expectResult(instrIn[5:0], rsIn, rtIn);
               mRemain    <= 33;
            end
            FN_MTHI: mHi <= rsIn;
            FN_MTLO: mLo <= rsIn;
            default: ;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         logic        cls, mf, expMfValid;
         logic [31:0] expMf;
         cls        = validIn && tbIsClass(instrIn);
         mf         = cls && (instrIn[5:0] == FN_MFHI || instrIn[5:0] == FN_MFLO);
         expMfValid = mf && !expBusy;
         expMf      = !expMfValid ? 32'h0 : (instrIn[5:0] == FN_MFHI) ? mHi : mLo;
         checkOutput("cycle.busy", 32'(busy_o), 32'(expBusy));
         checkOutput("cycle.stall", 32'(stall_o), 32'(cls && expBusy));
         checkOutput("cycle.mfValid", 32'(mfValid_o), 32'(expMfValid));
         checkOutput("cycle.mfResult", mfResult_o, expMf);
         checkOutput("cycle.hi", hi_o, mHi);
         checkOutput("cycle.lo", lo_o, mLo);
      end
   end

   // Present an instruction and hold it while the model says it would stall.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
      validIn = 1'b1;
      instrIn = {op, 20'h0, fn};
      rsIn    = rs;
      rtIn    = rt;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!expBusy || !tbIsClass(instrIn)) break;
      end
      @(posedge clk);
      #1;
      validIn = 1'b0;
      instrIn = '0;
   endtask

   task automatic waitIdle(output int cycles);
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy_o) return;
         cycles++;
      end
      checks++;
      failures++;
      $display("[TB] FAIL waitIdle: busy_o still 1 after 100 cycles, required 0");
   endtask

   task automatic serveMf(input string name, input logic [5:0] fn, input logic [31:0] expVal, input logic expStallFirst);
      validIn = 1'b1;
      instrIn = {6'h00, 20'h0, fn};
      @(negedge clk);
      checkOutput({name, ".stallFirst"}, 32'(stall_o), 32'(expStallFirst));
      checkOutput({name, ".validFirst"}, 32'(mfValid_o), 32'(!expStallFirst));
      for (int i = 0; i < 100 && expBusy; i++) @(negedge clk);
      checkOutput({name, ".valid"}, 32'(mfValid_o), 32'd1);
      checkOutput({name, ".result"}, mfResult_o, expVal);
      @(posedge clk);
      #1;
      validIn = 1'b0;
      instrIn = '0;
   endtask

   task automatic runOp(input string name, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] expHi, input logic [31:0] expLo);
      int cyc;
      applyStimulus(6'h00, fn, rs, rt);
      waitIdle(cyc);
      checkOutput({name, ".busyCycles"}, 32'(cyc), 32'd33);
      checkOutput({name, ".hi"}, hi_o, expHi);
      checkOutput({name, ".lo"}, lo_o, expLo);
   endtask

   initial begin
      int cyc;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.busy", 32'(busy_o), 32'd0);
      checkOutput("reset.stall", 32'(stall_o), 32'd0);
      checkOutput("reset.mfValid", 32'(mfValid_o), 32'd0);
      checkOutput("reset.hi", hi_o, 32'h0);
      checkOutput("reset.lo", lo_o, 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      runOp("mult",      FN_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
      runOp("multu",     FN_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA);
      runOp("div",       FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("divu",      FN_DIVU,  32'd7,        32'd2,        32'd1,        32'd3);
      runOp("divOvf",    FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
      runOp("divuZero",  FN_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF);
      runOp("divZero",   FN_DIV,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF);
      runOp("multMixed", FN_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);

      // MULT funct under a non-SPECIAL opcode must be ignored.
      applyStimulus(6'h1C, FN_MULT, 32'd5, 32'd5);
      @(negedge clk);
      checkOutput("nonSpecial.busy", 32'(busy_o), 32'd0);

      applyStimulus(6'h00, FN_MULT, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      serveMf("mfloHeld", FN_MFLO, 32'd42, 1'b1);

      applyStimulus(6'h00, FN_MULT, 32'd3, 32'd5);
      applyStimulus(6'h00, FN_DIVU, 32'd100, 32'd9);
      @(negedge clk);
      checkOutput("b2b.multHi", hi_o, 32'd0);
      checkOutput("b2b.multLo", lo_o, 32'd15);
      applyStimulus(6'h00, FN_ADD, 32'd1, 32'd2);
      waitIdle(cyc);
      checkOutput("b2b.divuCycles", 32'(cyc), 32'd31);
      checkOutput("b2b.divuHi", hi_o, 32'd1);
      checkOutput("b2b.divuLo", lo_o, 32'd11);

      applyStimulus(6'h00, FN_DIVU, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midReset.busy", 32'(busy_o), 32'd0);
      checkOutput("midReset.hi", hi_o, 32'h0);
      checkOutput("midReset.lo", lo_o, 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(6'h00, FN_MTHI, 32'hA5A5A5A5, 32'h0);
      serveMf("mfhiAfterMthi", FN_MFHI, 32'hA5A5A5A5, 1'b0);
      applyStimulus(6'h00, FN_MTLO, 32'h5A5A0001, 32'h0);
      serveMf("mfloAfterMtlo", FN_MFLO, 32'h5A5A0001, 1'b0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Execute-stage multiply/divide unit; consumes the decode/execute register outputs: the instruction word and the post-bypass rs/rt operands.
- Executes MULT, MULTU, DIV, DIVU iteratively and owns the architectural HI/LO registers.
- Services MFHI, MFLO, MTHI and MTLO.
- Raises a stall to freeze fetch/decode and the decode/execute register while an HI/LO-class instruction must wait for an in-flight operation.

Parameters:
- XLEN, 32, operand width; HI/LO are each XLEN bits.
- DIV0_LO, 32'hFFFFFFFF, LO value written on divide by zero.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX holds a real instruction, not a flushed bubble.
- instrData_i  in  32  EX instruction word; opcode = [31:26], funct = [5:0].
- rsData_i  in  XLEN  post-bypass rs operand.
- rtData_i  in  XLEN  post-bypass rt operand.
- busy_o  out  1  iterative operation in flight.
- stall_o  out  1  hold upstream stages and the decode/execute register this cycle.
- mfResult_o  out  XLEN  HI or LO value for an MFHI/MFLO in EX.
- mfValid_o  out  1  mfResult_o valid this cycle; writeback selects it.
- hi_o  out  XLEN  current HI register.
- lo_o  out  XLEN  current LO register.

Behaviour:
- Decode. Class instruction = opcode 0 with one of these funct codes:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO
  - Any other word, including the all-zero bubble, is ignored.
- Reset. rst_n low asynchronously forces state IDLE, HI=0, LO=0, counter=0, busy_o=0, stall_o=0, mfValid_o=0. This also applies mid-operation: the operation is abandoned and no partial result reaches HI/LO.
- States:
  - IDLE. Accept when valid_i, a class instruction, and busy_o=0.
  - MUL/DIV. Iterate 32 times, counter 0..31; go to FIX when counter=31.
  - FIX. Apply signs, write HI/LO, return to IDLE.
- Start. At accept edge E0, latch operand magnitudes and result-sign flags, then enter MUL (MULT/MULTU) or DIV (DIV/DIVU).
- Iterations:
  - Multiply: shift-add, one bit per edge at E1..E32.
  - Divide: restoring, one quotient bit per edge.
- Completion. The FIX edge is E33. busy_o is high from E0+ through E33- (33 cycles). HI/LO are visible from E33 onward.
- Signed multiply. 64-bit product = magnitude product, two's-complement negated if sign(rs) xor sign(rt). HI = [63:32], LO = [31:0].
- Signed divide:
  - Quotient sign = sign(rs) xor sign(rt); remainder sign = sign(rs).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero, signed or unsigned: full 33-cycle latency, then HI=rs, LO=DIV0_LO.
- MTHI/MTLO. Accepted in IDLE only; write HI/LO at the same edge; no busy cycles.
- MFHI/MFLO:
  - When IDLE: mfValid_o=1 and mfResult_o=HI/LO, combinationally in the same cycle.
  - When busy: mfValid_o=0.
- stall_o = valid_i & class instruction & busy_o, combinational. While it is high the instruction is held in EX.
  - A held MULT/DIV is accepted on the first cycle busy_o is low.
  - A held MF is served in that same cycle.
- Non-class instructions never stall and do not disturb an operation in flight.
- Back-to-back starts: a second start is blocked by stall_o, never overlapped.
- mfResult_o = 0 when mfValid_o=0.

Decomposition:
- Package mips_muldiv_pkg holds:
  - funct constants for the eight instructions and opcode SPECIAL=0;
  - state encoding IDLE/MUL/DIV/FIX;
  - iteration count 32.
- One sub-module, muldiv_iter_core, holds the shared shift register, adder/subtractor and counter. The top level keeps decode, the FSM, sign handling and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3 -> busy_o high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x1234, rt=0 -> after 33 cycles HI=0x1234, LO=0xFFFFFFFF. DIV rs=0xFFFFFFFF, rt=0 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- MULT 6*7, then MFLO presented 5 cycles after accept -> stall_o=1 and mfValid_o=0 until busy_o falls. In the next cycle mfValid_o=1 and mfResult_o=42.
- MULT accepted, then DIVU 100/9 immediately behind it -> DIVU stalls until MULT completes, is accepted on the first idle cycle, and finishes 33 cycles later with LO=11, HI=1; the MULT result is overwritten only then.
- rst_n pulsed low at cycle 10 of a DIVU -> busy_o, HI and LO read 0 immediately with no clock edge. Then MTHI 0xA5A5A5A5 followed by MFHI -> mfResult_o=0xA5A5A5A5 with no stall.
